// File: rtl/apb_pkg.sv
// Shared APB types and sizing for the requester and its watchdog.
// Default widths match the register slaves on the bus.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    localparam int APB_AWIDTH  = 4;
    localparam int APB_DWIDTH  = 8;
    localparam int APB_TIMEOUT = 15;

    // Counter width able to hold 0..t, never narrower than one bit.
    function automatic int wdog_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

    localparam int APB_WDOG_W = wdog_width(APB_TIMEOUT);

endpackage

// File: rtl/apb_wdog.sv
// Wait-state watchdog: counts ACCESS cycles with PREADY low and
// flags the cycle whose stall would be the TIMEOUT-th one.
module apb_wdog
    import apb_pkg::*;
#(
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = wdog_width(TIMEOUT);
    localparam logic [CW-1:0] LAST =
        CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] cnt;

    // Stall counter, cleared when a new transfer enters SETUP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A zero TIMEOUT disables the watchdog entirely.
    assign expired = (TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/apb_requester.sv
// APB initiator: one command at a time through SETUP/ACCESS,
// one-cycle response pulse, watchdog-bounded wait states.
module apb_requester
    import apb_pkg::*;
#(
    parameter int AWIDTH  = APB_AWIDTH,
    parameter int DWIDTH  = APB_DWIDTH,
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [AWIDTH-1:0] PADDR,
    output logic [DWIDTH-1:0] PWDATA,
    input  logic [DWIDTH-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_t state;
    apb_state_t state_nx;

    logic accept;
    logic done;
    logic tmo;
    logic wd_inc;
    logic wd_exp;

    apb_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk    (PCLK),
        .rst    (PRESET),
        .clr    (accept),
        .inc    (wd_inc),
        .expired(wd_exp)
    );

    // State register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and bus strobes; PSEL/PENABLE decode straight from
    // state so an asynchronous reset drops them at once.
    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        accept    = 1'b0;
        done      = 1'b0;
        tmo       = 1'b0;
        wd_inc    = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept   = 1'b1;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                PSEL     = 1'b1;
                state_nx = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end else begin
                    wd_inc = 1'b1;
                    if (wd_exp) begin
                        tmo      = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Command capture and response registers; bus fields hold in IDLE.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= done | tmo;
            if (accept) begin
                PWRITE <= cmd_write;
                PADDR  <= cmd_addr;
                PWDATA <= cmd_wdata;
            end
            if (done) begin
                rsp_rdata <= PWRITE ? '0 : PRDATA;
                rsp_err   <= PSLVERR;
            end else if (tmo) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: behavioural slave with programmable wait
// states, reference memory and latency rules checked per scenario.
module tb_apb_requester;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    logic          cmd_valid0 = 1'b0;
    logic          cmd_ready0;
    logic          rsp_valid0;
    logic [DW-1:0] rsp_rdata0;
    logic          rsp_err0;
    logic          PSEL0;
    logic          PENABLE0;
    logic          PWRITE0;
    logic [AW-1:0] PADDR0;
    logic [DW-1:0] PWDATA0;
    logic          PREADY0 = 1'b0;
    logic          PSLVERR0 = 1'b0;

    int checks = 0;
    int errors = 0;

    int s_waits = 0;
    bit s_err = 0;
    bit s_stuck = 0;
    int s_wcnt = 0;
    logic [DW-1:0] smem [16];
    logic [DW-1:0] ref_mem [16];

    always #5 PCLK = ~PCLK;

    apb_requester #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(15)) u_dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    apb_requester #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(0)) u_dut0 (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
        .rsp_err(rsp_err0),
        .PSEL(PSEL0), .PENABLE(PENABLE0), .PWRITE(PWRITE0),
        .PADDR(PADDR0), .PWDATA(PWDATA0), .PRDATA(PRDATA),
        .PREADY(PREADY0), .PSLVERR(PSLVERR0)
    );

    // Behavioural slave: ready after s_waits stalled ACCESS cycles.
    assign PREADY = PSEL && PENABLE && !s_stuck && (s_wcnt >= s_waits);
    assign PRDATA = (PSEL && PENABLE) ? smem[PADDR] : '0;
    assign PSLVERR = s_err;

    always @(posedge PCLK) begin
        if (PSEL && !PENABLE) s_wcnt <= 0;
        else if (PSEL && PENABLE && !PREADY) s_wcnt <= s_wcnt + 1;
        if (PSEL && PENABLE && PREADY && PWRITE) smem[PADDR] <= PWDATA;
    end

    // Drives one command and observes the resulting transfer.
    task automatic xfer(
        input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
        input int w, input bit e, input bit stk,
        output int lat, output int nsel, output int nen,
        output logic [DW-1:0] rd, output logic er,
        output bit hold_ok, output bit pulse_ok, output logic sel_rsp);
        @(negedge PCLK);
        s_waits = w; s_err = e; s_stuck = stk;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 0;
        lat = 1; nsel = 0; nen = 0; hold_ok = 1;
        while (!rsp_valid && lat < 100) begin
            nsel += int'(PSEL);
            nen += int'(PENABLE);
            if (PSEL && (PADDR !== a || PWRITE !== wr || PWDATA !== d))
                hold_ok = 0;
            lat++;
            @(negedge PCLK);
        end
        rd = rsp_rdata; er = rsp_err; sel_rsp = PSEL;
        @(negedge PCLK);
        pulse_ok = !rsp_valid && rsp_rdata === rd && rsp_err === er;
        s_stuck = 0; s_err = 0;
        if (wr) ref_mem[a] = d;
    endtask

    task automatic test_reset();
        PRESET = 1;
        repeat (2) @(negedge PCLK);
        checks++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== '0) begin
            errors++;
            $display("FAIL reset_bus got %0b%0b%0b %h %h want 0",
                     PSEL, PENABLE, PWRITE, PADDR, PWDATA);
        end
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_rsp got %0b %0b %h want 0",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %0b want 1", cmd_ready);
        end
        PRESET = 0;
    endtask

    task automatic test_zero_wait_write();
        int lat, ns, ne; logic [DW-1:0] rd; logic er, sr; bit h, p;
        xfer(1, 4'd2, 8'hA5, 0, 0, 0, lat, ns, ne, rd, er, h, p, sr);
        checks++;
        if (lat != 3) begin
            errors++; $display("FAIL zw_latency got %0d want 3", lat);
        end
        checks++;
        if (ns != 2 || ne != 1) begin
            errors++;
            $display("FAIL zw_strobes got psel %0d pen %0d want 2 1", ns, ne);
        end
        checks++;
        if (!h) begin
            errors++; $display("FAIL zw_bus got 0 want stable addr 2 data a5");
        end
        checks++;
        if (rd !== 8'h00 || er !== 1'b0) begin
            errors++; $display("FAIL zw_rsp got %h %0b want 00 0", rd, er);
        end
        checks++;
        if (!p || sr !== 1'b0) begin
            errors++; $display("FAIL zw_pulse got %0b %0b want 1 0", p, sr);
        end
        checks++;
        if (smem[2] !== 8'hA5) begin
            errors++; $display("FAIL zw_slave got %h want a5", smem[2]);
        end
    endtask

    task automatic test_wait_read();
        int lat, ns, ne; logic [DW-1:0] rd; logic er, sr; bit h, p;
        xfer(1, 4'd4, 8'h3C, 0, 0, 0, lat, ns, ne, rd, er, h, p, sr);
        xfer(0, 4'd4, 8'h00, 3, 0, 0, lat, ns, ne, rd, er, h, p, sr);
        checks++;
        if (lat != 6 || ne != 4) begin
            errors++;
            $display("FAIL ws_latency got %0d access %0d want 6 4", lat, ne);
        end
        checks++;
        if (rd !== 8'h3C || er !== 1'b0) begin
            errors++; $display("FAIL ws_rsp got %h %0b want 3c 0", rd, er);
        end
    endtask

    task automatic test_slave_error();
        int lat, ns, ne; logic [DW-1:0] rd; logic er, sr; bit h, p;
        xfer(1, 4'd1, 8'hFF, 0, 0, 0, lat, ns, ne, rd, er, h, p, sr);
        xfer(0, 4'd1, 8'h00, 0, 1, 0, lat, ns, ne, rd, er, h, p, sr);
        checks++;
        if (rd !== 8'hFF || er !== 1'b1) begin
            errors++; $display("FAIL err_rsp got %h %0b want ff 1", rd, er);
        end
        checks++;
        if (!p || lat != 3) begin
            errors++; $display("FAIL err_pulse got %0b lat %0d want 1 3", p, lat);
        end
    endtask

    task automatic test_timeout();
        int lat, ns, ne; logic [DW-1:0] rd; logic er, sr; bit h, p;
        xfer(0, 4'd2, 8'h00, 0, 0, 1, lat, ns, ne, rd, er, h, p, sr);
        checks++;
        if (ne != 15 || lat != 17) begin
            errors++;
            $display("FAIL to_cycles got access %0d lat %0d want 15 17", ne, lat);
        end
        checks++;
        if (rd !== 8'h00 || er !== 1'b1) begin
            errors++; $display("FAIL to_rsp got %h %0b want 00 1", rd, er);
        end
        checks++;
        if (sr !== 1'b0 || !p || PSEL !== 1'b0) begin
            errors++;
            $display("FAIL to_release got psel %0b pulse %0b want 0 1", sr, p);
        end
    endtask

    task automatic test_random();
        int lat, ns, ne; logic [DW-1:0] rd; logic er, sr; bit h, p;
        for (int i = 0; i < 16; i++) begin
            xfer(1, AW'(i), DW'($urandom), 0, 0, 0,
                 lat, ns, ne, rd, er, h, p, sr);
        end
        for (int i = 0; i < 24; i++) begin
            bit wr = bit'($urandom_range(0, 1));
            logic [AW-1:0] a = AW'($urandom_range(0, 15));
            logic [DW-1:0] d = DW'($urandom);
            int w = int'($urandom_range(0, 4));
            bit e = ($urandom_range(0, 3) == 0);
            logic [DW-1:0] exp_rd = wr ? '0 : ref_mem[a];
            xfer(wr, a, d, w, e, 0, lat, ns, ne, rd, er, h, p, sr);
            checks++;
            if (rd !== exp_rd || er !== e || lat != 3 + w || !h || !p) begin
                errors++;
                $display("FAIL rnd%0d got %h %0b lat %0d want %h %0b lat %0d",
                         i, rd, er, lat, exp_rd, e, 3 + w);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0, rsp = 0, t = 0, last = 0;
        int lat, ns, ne; logic [DW-1:0] rd; logic er, sr; bit h, p;
        @(negedge PCLK);
        s_waits = 0; s_err = 0; s_stuck = 0;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 0; cmd_wdata = 8'd10;
        while ((acc < 5 || rsp < 5) && t < 60) begin
            if (rsp_valid) rsp++;
            if (cmd_valid && cmd_ready) begin
                if (acc > 0) begin
                    checks++;
                    if (!rsp_valid || t - last != 3) begin
                        errors++;
                        $display("FAIL b2b_gap got rsp %0b gap %0d want 1 3",
                                 rsp_valid, t - last);
                    end
                end
                last = t;
                ref_mem[acc] = DW'(10 + acc);
                acc++;
            end
            @(negedge PCLK);
            t++;
            if (acc < 5) begin
                cmd_addr = AW'(acc);
                cmd_wdata = DW'(10 + acc);
            end else begin
                cmd_valid = 0;
            end
        end
        checks++;
        if (acc != 5 || rsp != 5) begin
            errors++; $display("FAIL b2b_count got %0d %0d want 5 5", acc, rsp);
        end
        for (int i = 0; i < 5; i++) begin
            xfer(0, AW'(i), 8'h00, 0, 0, 0, lat, ns, ne, rd, er, h, p, sr);
            checks++;
            if (rd !== ref_mem[i] || rd !== DW'(10 + i)) begin
                errors++;
                $display("FAIL b2b_read%0d got %0d want %0d", i, rd, 10 + i);
            end
        end
    endtask

    task automatic test_reset_mid();
        int spurious = 0, notready = 0;
        @(negedge PCLK);
        s_stuck = 1;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 4'd3;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 0;
        repeat (4) @(negedge PCLK);
        checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
            errors++;
            $display("FAIL rm_access got %0b %0b want 1 1", PSEL, PENABLE);
        end
        #2 PRESET = 1;
        #1;
        checks++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0
            || PADDR !== '0) begin
            errors++;
            $display("FAIL rm_async got %0b %0b %0b %h want 0 0 0 0",
                     PSEL, PENABLE, rsp_valid, PADDR);
        end
        @(negedge PCLK);
        PRESET = 0;
        s_stuck = 0;
        repeat (20) begin
            @(negedge PCLK);
            if (rsp_valid) spurious++;
            if (!cmd_ready) notready++;
        end
        checks++;
        if (spurious != 0 || notready != 0) begin
            errors++;
            $display("FAIL rm_after got rsp %0d notready %0d want 0 0",
                     spurious, notready);
        end
    endtask

    task automatic test_no_watchdog();
        int seen = 0;
        @(negedge PCLK);
        cmd_valid0 = 1; cmd_write = 0; cmd_addr = 4'd6;
        @(negedge PCLK);
        cmd_valid0 = 0;
        repeat (100) begin
            @(negedge PCLK);
            if (rsp_valid0) seen++;
        end
        checks++;
        if (seen != 0 || PSEL0 !== 1'b1 || PENABLE0 !== 1'b1) begin
            errors++;
            $display("FAIL nowd got rsp %0d psel %0b pen %0b want 0 1 1",
                     seen, PSEL0, PENABLE0);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_write();
        test_wait_read();
        test_slave_error();
        test_timeout();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_no_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
